// File: rtl/csel_pkg.sv
// Shared definitions for the pipelined carry-select adder.
//   OP_ADD / OP_SUB : encoding of the in_sub operation select
//   SLICE / NBLK    : slice and block counts for the default 32/4/4 configuration
//   cfg_ok()        : true when WIDTH splits evenly into STAGES slices of whole BLOCKs
package csel_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int WIDTH_DEF  = 32;
    localparam int BLOCK_DEF  = 4;
    localparam int STAGES_DEF = 4;

    localparam int SLICE = WIDTH_DEF / STAGES_DEF;
    localparam int NBLK  = SLICE / BLOCK_DEF;

    function automatic bit cfg_ok(input int width, input int stages, input int block);
        return (stages > 0) && (block > 0) && ((width % (stages * block)) == 0);
    endfunction

endpackage

// File: rtl/csel_block.sv
// One carry-select block: two BLOCK-bit ripple adders evaluated with carry-in 0
// and carry-in 1; the real carry-in then picks the sum and the carry-out.
//   a, b : block operands
//   cin  : actual carry into the block
//   sum  : selected block sum
//   cout : selected block carry-out
module csel_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout
);

    logic [BLOCK-1:0] s0;
    logic [BLOCK-1:0] s1;
    logic             c0;
    logic             c1;

    always_comb begin
        s0 = '0;
        s1 = '0;
        c0 = 1'b0;
        c1 = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            s0[i] = a[i] ^ b[i] ^ c0;
            c0    = (a[i] & b[i]) | (c0 & (a[i] ^ b[i]));
            s1[i] = a[i] ^ b[i] ^ c1;
            c1    = (a[i] & b[i]) | (c1 & (a[i] ^ b[i]));
        end
    end

    // c0 implies c1, so c1 only matters when the real carry-in is 1.
    assign sum  = cin ? s1 : s0;
    assign cout = (c1 & cin) | c0;

endmodule

// File: rtl/csel_pipe_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready handshakes.
//   clk, rst_n                    : clock, async active-low reset
//   in_valid/in_ready             : operand handshake
//   in_a, in_b, in_cin, in_sub    : operands, carry-in (ADD only), 1 = subtract
//   out_valid/out_ready           : result handshake
//   out_sum, out_cout             : result and MSB carry (SUB: 1 = no borrow)
//   out_ovf, out_zero             : signed overflow, result == 0
// Bank k registers feed slice k; the whole pipe advances together, so a stalled
// output freezes every stage and no bubble is squeezed out.
module csel_pipe_adder
    import csel_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int SLICE_W = WIDTH / STAGES;
    localparam int NBLK_N  = SLICE_W / BLOCK;
    localparam int LAST    = STAGES - 1;

    if (!cfg_ok(WIDTH, STAGES, BLOCK)) begin : g_cfg_err
        $error("csel_pipe_adder: WIDTH must be divisible by STAGES*BLOCK");
    end

    logic adv;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] out_sum_d, out_sum_q;
    logic             out_cout_d, out_cout_q;
    logic             out_ovf_d, out_ovf_q;
    logic             out_zero_d, out_zero_q;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        // a/b hold only the operand bits not yet consumed (bit 0 = absolute k*SLICE_W).
        // cs holds the finished lower sum bits with the pending carry on top.
        localparam int AW = WIDTH - k * SLICE_W;
        localparam int CW = k * SLICE_W + 1;

        logic [AW-1:0]         a_d, a_q;
        logic [AW-1:0]         b_d, b_q;
        logic [CW-1:0]         cs_d, cs_q;
        logic                  v_d, v_q;
        logic [NBLK_N:0]       carry;
        logic [SLICE_W-1:0]    slice_sum;
        logic [CW+SLICE_W-1:0] cs_nx;

        if (k == 0) begin : g_entry
            always_comb begin
                a_d  = in_a;
                b_d  = (in_sub == OP_SUB) ? ~in_b : in_b;
                cs_d = (in_sub == OP_SUB) ? 1'b1 : in_cin;
                v_d  = in_valid;
            end
        end else begin : g_skew
            always_comb begin
                a_d  = g_stg[k-1].a_q[AW+SLICE_W-1:SLICE_W];
                b_d  = g_stg[k-1].b_q[AW+SLICE_W-1:SLICE_W];
                cs_d = g_stg[k-1].cs_nx;
                v_d  = g_stg[k-1].v_q;
            end
        end

        always_ff @(posedge clk) begin
            if (adv) begin
                a_q  <= a_d;
                b_q  <= b_d;
                cs_q <= cs_d;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
            end else if (adv) begin
                v_q <= v_d;
            end
        end

        assign carry[0] = cs_q[CW-1];

        for (genvar j = 0; j < NBLK_N; j++) begin : g_blk
            csel_block #(
                .BLOCK(BLOCK)
            ) u_blk (
                .a   (a_q[j*BLOCK +: BLOCK]),
                .b   (b_q[j*BLOCK +: BLOCK]),
                .cin (carry[j]),
                .sum (slice_sum[j*BLOCK +: BLOCK]),
                .cout(carry[j+1])
            );
        end

        always_comb begin
            cs_nx = '0;
            for (int i = 0; i < CW - 1; i++) begin
                cs_nx[i] = cs_q[i];
            end
            cs_nx[CW-1 +: SLICE_W] = slice_sum;
            cs_nx[CW+SLICE_W-1]    = carry[NBLK_N];
        end
    end

    // Carry into the MSB is recovered as a^b^sum at that bit.
    always_comb begin
        out_sum_d   = g_stg[LAST].cs_nx[WIDTH-1:0];
        out_cout_d  = g_stg[LAST].cs_nx[WIDTH];
        out_ovf_d   = g_stg[LAST].a_q[SLICE_W-1] ^ g_stg[LAST].b_q[SLICE_W-1]
                    ^ out_sum_d[WIDTH-1] ^ out_cout_d;
        out_zero_d  = ~|out_sum_d;
        out_valid_d = g_stg[LAST].v_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_zero_q  <= 1'b0;
        end else if (adv) begin
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_cout_q  <= out_cout_d;
            out_ovf_q   <= out_ovf_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_csel_pipe_adder.sv
// Self-checking bench for csel_pipe_adder (default 32/4/4 configuration).
// Expected results are queued at accept time and compared in order by a monitor.
module tb_csel_pipe_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic        in_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        out_zero;

    int          total = 0;
    int          bad = 0;
    int          tx_cnt = 0;
    int          rx_cnt = 0;
    int          cyc = 0;
    logic [34:0] exp_q[$];
    string       tag_q[$];
    logic [34:0] mon_e;
    string       mon_t;

    csel_pipe_adder #(
        .WIDTH(32),
        .BLOCK(4),
        .STAGES(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf),
        .out_zero (out_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {cout, ovf, zero, sum}
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [31:0] bb;
        logic [32:0] r;
        logic        ovf;
        bb  = sub ? ~b : b;
        r   = {1'b0, a} + {1'b0, bb} + 33'(sub ? 1'b1 : cin);
        ovf = (a[31] == bb[31]) && (r[31] != a[31]);
        return {r[32], ovf, (r[31:0] == 32'd0), r[31:0]};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_t = tag_q.pop_front();
                check(mon_t, {29'd0, out_cout, out_ovf, out_zero, out_sum}, {29'd0, mon_e});
                rx_cnt++;
            end
        end
    end

    task automatic send_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub, input logic [34:0] exp);
        int  n;
        bit  done;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = 1'b1;
        n        = 0;
        done     = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(exp);
                tag_q.push_back(tag);
                tx_cnt++;
                done = 1'b1;
            end else begin
                n++;
                if (n > 50) begin
                    check("send_timeout", 64'(n), 64'd50);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called right after an accept edge with in_valid dropped: result must show
    // only after the fourth following edge.
    task automatic wait_latency(input string tag);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check({tag, "_early"}, 64'(out_valid), 64'd0);
        end
        @(negedge clk);
        check({tag, "_due"}, 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    logic [31:0] dv_a[6]   = '{32'h7FFF_FFFF, 32'h0000_000F, 32'h0000_0005, 32'h8000_0000, 32'h0000_0005, 32'h0000_0007};
    logic [31:0] dv_b[6]   = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0007, 32'h0000_0001, 32'h0000_0007, 32'h0000_0007};
    logic        dv_cin[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        dv_sub[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    // {cout, ovf, zero, sum}, worked by hand
    logic [34:0] dv_exp[6] = '{{3'b010, 32'h8000_0000},
                               {3'b000, 32'h0000_0010},
                               {3'b000, 32'hFFFF_FFFE},
                               {3'b110, 32'h7FFF_FFFF},
                               {3'b000, 32'hFFFF_FFFE},
                               {3'b101, 32'h0000_0000}};
    string       dv_tag[6] = '{"add_ovf", "add_cin", "sub_neg", "sub_ovf", "sub_cin_ignored", "sub_zero"};

    logic [31:0] held;
    int          c0;
    logic [31:0] ra, rb;
    logic        rc, rs;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_flags", 64'({out_cout, out_ovf, out_zero}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        send_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {3'b101, 32'h0});
        wait_latency("lat_first");

        for (int i = 0; i < 6; i++) begin
            send_op(dv_tag[i], dv_a[i], dv_b[i], dv_cin[i], dv_sub[i], dv_exp[i]);
        end
        drain();

        c0 = cyc;
        for (int i = 0; i < 100; i++) begin
            ra = $urandom; rb = $urandom;
            rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            send_op("rand", ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        check("throughput_cycles", 64'(cyc - c0), 64'd100);
        drain();

        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    ra = $urandom; rb = $urandom;
                    rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
                    send_op("stall_stream", ra, rb, rc, rs, model(ra, rb, rc, rs));
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    check("stall_out_valid", 64'(out_valid), 64'd1);
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                    if (i == 0) held = out_sum;
                    else check("stall_hold", 64'(out_sum), 64'(held));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("count_in_out", 64'(rx_cnt), 64'(tx_cnt));

        send_op("rst_flight0", 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, model(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0));
        in_valid = 1'b1;
        send_op("rst_flight1", 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, model(32'h3, 32'h4, 1'b0, 1'b0));
        send_op("rst_flight2", 32'h0000_0009, 32'h0000_0002, 1'b0, 1'b1, model(32'h9, 32'h2, 1'b0, 1'b1));
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_sum", 64'(out_sum), 64'd0);
        check("midrst_flags", 64'({out_cout, out_ovf, out_zero}), 64'd0);
        exp_q.delete();
        tag_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_idle", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send_op("post_rst_op", 32'h0000_000F, 32'h0000_0000, 1'b1, 1'b0, {3'b000, 32'h0000_0010});
        wait_latency("lat_post_rst");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/csel_pipe_adder.md
# csel_pipe_adder

Parametrised, pipelined carry-select adder/subtractor for the datapath ALU. It replaces the fixed 32-bit combinational carry-select adder. The carry chain is split into STAGES register-separated slices so the clock period is set by one slice rather than the full width. Operands enter and results leave through valid/ready handshakes. Throughput is one operation per cycle when unstalled, and the block adds subtract mode plus status flags.

## Interface
- WIDTH, 32: operand/result width; must be divisible by STAGES*BLOCK.
- BLOCK, 4: carry-select block width inside a slice.
- STAGES, 4: pipeline depth; each stage resolves WIDTH/STAGES bits (SLICE).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand transfer request.
- in_ready  out  1  block accepts operands this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry in; used in ADD only.
- in_sub  in  1  0 = ADD (A+B+cin), 1 = SUB (A+~B+1).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry out of MSB; in SUB, 1 = no borrow.
- out_ovf  out  1  two's-complement signed overflow.
- out_zero  out  1  out_sum == 0.

## Operation
- Transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
- Global advance: adv = !out_valid || out_ready. in_ready = adv. All pipeline registers, including the valid bits, load only when adv = 1; otherwise they hold.
- Stage k (0..STAGES-1) adds bits [k*SLICE +: SLICE] using the carry registered by stage k-1; stage 0 uses the effective cin.
- In SUB, B is inverted at entry and the effective cin is 1; in_cin is ignored.
- Within a slice, each BLOCK is computed twice (carry 0 and carry 1). The block's actual carry-in selects both the sum and the carry: c_out = c1&cin | c0.
- Skew registers:
  - Unprocessed upper operand bits travel with the operation.
  - Completed lower sum bits travel forward to the output.
- Stage valid bits shift with adv. Bubbles (in_valid = 0) propagate as valid = 0 and are not collapsed.
- Flags are computed combinationally in the last stage from final-stage values and registered with the sum:
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = ~|sum.
- out_* data holds stable while out_valid && !out_ready.
- Data registers have no reset requirement. The valid bits and all outputs reset.

## Timing
- Reset (rst_n = 0, async):
  - All valid bits clear.
  - out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0, out_zero = 0.
  - in_ready = 1 once rst_n is high (combinational from out_valid).
- An operation accepted at edge N produces out_valid = 1 after edge N+STAGES, provided adv stays 1 throughout.
- Full throughput: one accept per cycle with out_ready held 1.
- Stall: out_valid && !out_ready drops in_ready the same cycle. No operation is lost or duplicated; up to STAGES operations stay resident.
- Simultaneous accept and output transfer in one cycle is legal and required.
- Reset mid-operation discards every in-flight operation. No output appears after rst_n deasserts until a new accept.
- STAGES = 1 degenerates to a single registered carry-select adder with latency 1.

## Structure
- Shared package csel_pkg:
  - Op encoding constants OP_ADD = 0, OP_SUB = 1.
  - Parameter-check localparams: SLICE = WIDTH/STAGES, NBLK = SLICE/BLOCK.
  - An elaboration-time check that fails if WIDTH % (STAGES*BLOCK) != 0.
- One sub-module, csel_block: a BLOCK-bit dual ripple adder (carry 0 / carry 1) with output mux and carry select, instantiated NBLK times per stage via generate.
- Top level owns the stage registers, skew registers, valid chain and flag logic.

## Test plan
- Defaults; ADD 0xFFFFFFFF + 0x00000001, cin = 0 -> after 4 cycles: sum 0x00000000, cout 1, ovf 0, zero 1.
- ADD 0x7FFFFFFF + 0x00000001 -> sum 0x80000000, cout 0, ovf 1, zero 0. ADD 0x0000000F + 0x00000000, cin = 1 -> sum 0x00000010.
- SUB 5 - 7 -> sum 0xFFFFFFFE, cout 0, ovf 0. SUB 0x80000000 - 1 -> sum 0x7FFFFFFF, cout 1, ovf 1. Confirm in_cin = 1 is ignored in SUB.
- 100 random back-to-back ops with out_ready = 1 -> one result per cycle, in order, each matching the reference model.
- out_ready held 0 for 6 cycles mid-stream:
  - in_ready falls the same cycle and out_sum stays stable.
  - After release, results resume in order with none lost or duplicated.
- Assert rst_n low with 3 ops in flight -> outputs zero immediately. After release, no out_valid until a new op, whose result then arrives at latency 4.
